seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector; next generation of the team's fixed-pattern Detector FSMs.
- Samples one serial bit per enabled clock and compares the most recent PAT_LEN bits against a runtime-loadable pattern register.
- Emits a registered one-cycle match pulse.
- Supports overlapping and non-overlapping detection, selected by parameter.
- Sits between serial input conditioning and control/status logic.

Parameters:
- PAT_LEN, 4, pattern length in bits. Legal range 2..32; out-of-range values are an elaboration error.
- PATTERN, 4'b1001, reset value of the pattern register, PAT_LEN bits wide. The MSB is the first bit received.
- OVERLAP, 1, detection mode. 1 = overlapping, so the trailing bits of a match may start the next match. 0 = non-overlapping, so history is discarded after each match.
- CNT_W, 8, width of the match counter (used only with SEQ_DET_CNT_EN).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample enable; x is consumed only on edges where en=1.
- x  input  1  serial data bit.
- pat_ld  input  1  load pat_data into the pattern register.
- pat_data  input  PAT_LEN  new pattern, MSB first.
- y  output  1  registered match pulse.
- fill  output  $clog2(PAT_LEN+1)  number of valid history bits, 0..PAT_LEN.
- match_cnt  output  CNT_W  match counter; present only with SEQ_DET_CNT_EN.
- clr_cnt  input  1  synchronous counter clear; present only with SEQ_DET_CNT_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (rst=1 at an edge): pat <= PATTERN, hist <= 0, fill <= 0, y <= 0, match_cnt <= 0. rst overrides all other inputs.
- Priority at each edge: rst > pat_ld > en.
- pat_ld=1:
  - pat <= pat_data; hist <= 0; fill <= 0; y <= 0.
  - x is ignored that edge, regardless of en.
  - The first bit that can count toward the new pattern is sampled on the next enabled edge.
- en=0 (no rst, no pat_ld): pat, hist, fill and match_cnt hold; y <= 0. y is therefore never high for more than one cycle per match.
- en=1 sample:
  - nh = {hist[PAT_LEN-2:0], x}.
  - match = (fill >= PAT_LEN-1) && (nh == pat).
  - hist <= nh; y <= match.
- fill update:
  - No match: fill <= min(fill+1, PAT_LEN).
  - Match with OVERLAP=1: fill <= PAT_LEN.
  - Match with OVERLAP=0: fill <= 0, so the next PAT_LEN bits must be fresh.
- Latency: y is high for exactly one clock cycle, the cycle immediately after the edge that sampled the final pattern bit.
- Back-to-back matches:
  - Possible only with OVERLAP=1 and a self-overlapping pattern (e.g. 1111 on a stream of all 1s).
  - y then stays high on consecutive cycles, one cycle per match.
- The first match needs at least PAT_LEN enabled samples after reset or pat_ld. Stale history zeros never produce a match: an all-zero pattern does not fire until fill reaches PAT_LEN-1 prior samples.
- Reset mid-sequence: partial progress is lost and the pattern reverts to PATTERN. If y was high, it drops in the cycle after the reset edge.

Optional Feature:
- Macro SEQ_DET_CNT_EN.
- Defined:
  - match_cnt and clr_cnt ports exist.
  - match_cnt increments on every edge where match=1 and saturates at 2^CNT_W-1 with no wrap.
  - clr_cnt=1 clears the counter to 0. On a simultaneous match, clear wins and that match is not counted.
  - pat_ld does not clear the counter; rst does.
- Undefined: ports absent, no counter logic. All other behaviour is identical.

Test Plan:
- Reset/fill: rst=1 for 2 edges, then en=1, x=1,0,0 -> y stays 0 and fill steps 1,2,3. After rst, y=0, fill=0 and pat=4'b1001.
- Overlap (OVERLAP=1, pattern 1001): en=1, x = 1,0,0,1,0,1,0,0,1,0,0,1,1,0,1 -> y pulses the cycle after bits at indices 3, 8 and 11; 3 pulses total; match_cnt=3.
- Non-overlap (OVERLAP=0): same stream -> y pulses after indices 3 and 8 only; fill=0 after each match; match_cnt=2.
- Enable gaps and pattern load:
  - Stream 1,0,0,1 with en=0 inserted for 3 cycles between bits -> exactly one y pulse, 1 cycle wide, and fill holds during the gaps.
  - pat_ld with pat_data=4'b0110 mid-stream -> fill=0.
  - Then x=0,1,1,0 -> one pulse.
- Self-overlap: pattern 1111, OVERLAP=1, six 1s -> y high for 3 consecutive cycles. With OVERLAP=0 -> one pulse only.
- Counter edge cases (CNT_W=2): 5 matches -> match_cnt saturates at 3. clr_cnt coincident with a match -> match_cnt=0.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector: compares the last PAT_LEN sampled bits against a loadable pattern.
// Optional saturating match counter enabled by defining SEQ_DET_CNT_EN.
module seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         x,
    input  logic                         pat_ld,
    input  logic [PAT_LEN-1:0]           pat_data,
    output logic                         y,
    output logic [$clog2(PAT_LEN+1)-1:0] fill
`ifdef SEQ_DET_CNT_EN
    ,
    input  logic                         clr_cnt,
    output logic [CNT_W-1:0]             match_cnt
`endif
);

    localparam int                FILL_W   = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_LEN - 1);

    generate
        if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_pat_len
            $error("seq_detector_param: PAT_LEN must be in 2..32");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("seq_detector_param: CNT_W must be at least 1");
        end
    endgenerate

    logic [PAT_LEN-1:0] pat_reg;
    logic [PAT_LEN-2:0] hist_reg;
    logic [PAT_LEN-1:0] hist_next;
    logic [FILL_W-1:0]  fill_reg;
    logic [FILL_W-1:0]  fill_next;
    logic               y_reg;
    logic [PAT_LEN-1:0] eq_bits;
    logic               match;

    // Only PAT_LEN-1 bits of history are kept; the newest bit comes straight from x.
    assign hist_next = {hist_reg, x};

    generate
        for (genvar gi = 0; gi < PAT_LEN; gi++) begin : g_cmp
            assign eq_bits[gi] = hist_next[gi] ~^ pat_reg[gi];
        end
    endgenerate

    // Gating on fill keeps reset/cleared history zeros from matching an all-zero pattern.
    assign match = (fill_reg >= FILL_ARM) && (&eq_bits);

    always_comb begin
        fill_next = fill_reg;
        if (match) begin
            fill_next = OVERLAP ? FILL_MAX : '0;
        end else if (fill_reg != FILL_MAX) begin
            fill_next = fill_reg + FILL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_reg  <= PATTERN;
            hist_reg <= '0;
            fill_reg <= '0;
            y_reg    <= 1'b0;
        end else if (pat_ld) begin
            pat_reg  <= pat_data;
            hist_reg <= '0;
            fill_reg <= '0;
            y_reg    <= 1'b0;
        end else if (en) begin
            hist_reg <= hist_next[PAT_LEN-2:0];
            fill_reg <= fill_next;
            y_reg    <= match;
        end else begin
            y_reg    <= 1'b0;
        end
    end

    assign y    = y_reg;
    assign fill = fill_reg;

`ifdef SEQ_DET_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_reg;

    // Clear beats a coincident match; a load edge never samples, so it never counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr_cnt) begin
            cnt_reg <= '0;
        end else if (!pat_ld && en && match && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: one overlapping and one non-overlapping instance share stimulus;
// a vector table feeds a scoreboard queue that is checked one cycle after each drive.
module tb_seq_detector_param;

    localparam int PAT_LEN = 4;
    localparam int FW      = $clog2(PAT_LEN + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          x;
    logic          pat_ld;
    logic [3:0]    pat_data;
    logic          y_ov;
    logic          y_nov;
    logic [FW-1:0] fill_ov;
    logic [FW-1:0] fill_nov;
`ifdef SEQ_DET_CNT_EN
    logic          clr_cnt;
    logic [7:0]    cnt_ov;
    logic [1:0]    cnt_nov;
`endif

    always #5 clk = ~clk;

    seq_detector_param #(
        .PAT_LEN(PAT_LEN), .PATTERN(4'b1001), .OVERLAP(1'b1), .CNT_W(8)
    ) u_ov (
        .clk(clk), .rst(rst), .en(en), .x(x), .pat_ld(pat_ld), .pat_data(pat_data),
        .y(y_ov), .fill(fill_ov)
`ifdef SEQ_DET_CNT_EN
        , .clr_cnt(clr_cnt), .match_cnt(cnt_ov)
`endif
    );

    seq_detector_param #(
        .PAT_LEN(PAT_LEN), .PATTERN(4'b1001), .OVERLAP(1'b0), .CNT_W(2)
    ) u_nov (
        .clk(clk), .rst(rst), .en(en), .x(x), .pat_ld(pat_ld), .pat_data(pat_data),
        .y(y_nov), .fill(fill_nov)
`ifdef SEQ_DET_CNT_EN
        , .clr_cnt(clr_cnt), .match_cnt(cnt_nov)
`endif
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       x;
        logic       ld;
        logic [3:0] pd;
        logic       clr;
        logic       yo;
        int         fo;
        logic       yn;
        int         fn;
        int         co;   // -1: counter not checked on this vector
        int         cn;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic e, input logic xx, input logic l,
                       input logic [3:0] pd, input logic c,
                       input logic yo, input int fo, input logic yn, input int fn,
                       input int co, input int cn);
        vec_t v;
        v.rst = r; v.en = e; v.x = xx; v.ld = l; v.pd = pd; v.clr = c;
        v.yo = yo; v.fo = fo; v.yn = yn; v.fn = fn; v.co = co; v.cn = cn;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        // Reset, then fill stepping 1,2,3 as the overlap stream begins.
        add(1,0,0,0,4'h0,0, 0,0, 0,0, 0,0);
        add(1,0,0,0,4'h0,0, 0,0, 0,0, 0,0);
        // Stream 1,0,0,1,0,1,0,0,1,0,0,1,1,0,1 with pattern 1001.
        add(0,1,1,0,4'h0,0, 0,1, 0,1, -1,-1);
        add(0,1,0,0,4'h0,0, 0,2, 0,2, -1,-1);
        add(0,1,0,0,4'h0,0, 0,3, 0,3, -1,-1);
        add(0,1,1,0,4'h0,0, 1,4, 1,0, -1,-1);
        add(0,1,0,0,4'h0,0, 0,4, 0,1, -1,-1);
        add(0,1,1,0,4'h0,0, 0,4, 0,2, -1,-1);
        add(0,1,0,0,4'h0,0, 0,4, 0,3, -1,-1);
        add(0,1,0,0,4'h0,0, 0,4, 0,4, -1,-1);
        add(0,1,1,0,4'h0,0, 1,4, 1,0, -1,-1);
        add(0,1,0,0,4'h0,0, 0,4, 0,1, -1,-1);
        add(0,1,0,0,4'h0,0, 0,4, 0,2, -1,-1);
        add(0,1,1,0,4'h0,0, 1,4, 0,3, -1,-1);
        add(0,1,1,0,4'h0,0, 0,4, 0,4, -1,-1);
        add(0,1,0,0,4'h0,0, 0,4, 0,4, -1,-1);
        add(0,1,1,0,4'h0,0, 0,4, 0,4, 3,2);
        // Enable gaps: bits 1,0,0,1 with three idle cycles between; x toggled while idle.
        add(1,0,0,0,4'h0,0, 0,0, 0,0, 0,0);
        add(0,1,1,0,4'h0,0, 0,1, 0,1, -1,-1);
        for (int g = 0; g < 3; g++) add(0,0,0,0,4'h0,0, 0,1, 0,1, -1,-1);
        add(0,1,0,0,4'h0,0, 0,2, 0,2, -1,-1);
        for (int g = 0; g < 3; g++) add(0,0,1,0,4'h0,0, 0,2, 0,2, -1,-1);
        add(0,1,0,0,4'h0,0, 0,3, 0,3, -1,-1);
        for (int g = 0; g < 3; g++) add(0,0,1,0,4'h0,0, 0,3, 0,3, -1,-1);
        add(0,1,1,0,4'h0,0, 1,4, 1,0, -1,-1);
        add(0,0,1,0,4'h0,0, 0,4, 0,0, 1,1);
        // Load 0110 with en=1 (x ignored); counter survives the load.
        add(0,1,0,1,4'b0110,0, 0,0, 0,0, 1,1);
        add(0,1,0,0,4'h0,0, 0,1, 0,1, -1,-1);
        add(0,1,1,0,4'h0,0, 0,2, 0,2, -1,-1);
        add(0,1,1,0,4'h0,0, 0,3, 0,3, -1,-1);
        add(0,1,0,0,4'h0,0, 1,4, 1,0, 2,2);
        // Self-overlap 1111 on twelve 1s: overlap fires every cycle from the 4th bit.
        add(0,0,0,1,4'b1111,0, 0,0, 0,0, 2,2);
        add(0,1,1,0,4'h0,0, 0,1, 0,1, -1,-1);
        add(0,1,1,0,4'h0,0, 0,2, 0,2, -1,-1);
        add(0,1,1,0,4'h0,0, 0,3, 0,3, -1,-1);
        add(0,1,1,0,4'h0,0, 1,4, 1,0, 3,3);
        add(0,1,1,0,4'h0,0, 1,4, 0,1, -1,-1);
        add(0,1,1,0,4'h0,0, 1,4, 0,2, -1,-1);
        add(0,1,1,0,4'h0,0, 1,4, 0,3, -1,-1);
        add(0,1,1,0,4'h0,0, 1,4, 1,0, 7,3);
        add(0,1,1,0,4'h0,0, 1,4, 0,1, -1,-1);
        add(0,1,1,0,4'h0,0, 1,4, 0,2, -1,-1);
        add(0,1,1,0,4'h0,0, 1,4, 0,3, -1,-1);
        add(0,1,1,0,4'h0,0, 1,4, 1,0, 11,3);
        // Clear coincident with an overlapping match: the match is not counted.
        add(0,1,1,0,4'h0,1, 1,4, 0,1, 0,0);
        add(0,1,1,0,4'h0,0, 1,4, 0,2, 1,0);
        // Reset while y is high and pat_ld asserted: reset wins, pattern reverts to 1001.
        add(1,1,1,1,4'b0110,0, 0,0, 0,0, 0,0);
        add(0,1,1,0,4'h0,0, 0,1, 0,1, -1,-1);
        add(0,1,0,0,4'h0,0, 0,2, 0,2, -1,-1);
        add(0,1,0,0,4'h0,0, 0,3, 0,3, -1,-1);
        add(0,1,1,0,4'h0,0, 1,4, 1,0, 1,1);
        // All-zero pattern: no fire before PAT_LEN fresh samples.
        add(0,1,0,1,4'b0000,0, 0,0, 0,0, 1,1);
        add(0,1,0,0,4'h0,0, 0,1, 0,1, -1,-1);
        add(0,1,0,0,4'h0,0, 0,2, 0,2, -1,-1);
        add(0,1,0,0,4'h0,0, 0,3, 0,3, -1,-1);
        add(0,1,0,0,4'h0,0, 1,4, 1,0, 2,2);
        add(0,1,0,0,4'h0,0, 1,4, 0,1, 3,2);

        rst = 1'b1; en = 1'b0; x = 1'b0; pat_ld = 1'b0; pat_data = 4'h0;
`ifdef SEQ_DET_CNT_EN
        clr_cnt = 1'b0;
`endif
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t e;
            rst = vecs[i].rst; en = vecs[i].en; x = vecs[i].x;
            pat_ld = vecs[i].ld; pat_data = vecs[i].pd;
`ifdef SEQ_DET_CNT_EN
            clr_cnt = vecs[i].clr;
`endif
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            $display("vec %0d: rst=%b en=%b x=%b ld=%b y_ov=%b fill_ov=%0d y_nov=%b fill_nov=%0d",
                     i, e.rst, e.en, e.x, e.ld, y_ov, fill_ov, y_nov, fill_nov);
            chk("y_ov", i, 32'(y_ov), 32'(e.yo));
            chk("fill_ov", i, 32'(fill_ov), e.fo);
            chk("y_nov", i, 32'(y_nov), 32'(e.yn));
            chk("fill_nov", i, 32'(fill_nov), e.fn);
`ifdef SEQ_DET_CNT_EN
            if (e.co >= 0) chk("cnt_ov", i, 32'(cnt_ov), e.co);
            if (e.cn >= 0) chk("cnt_nov", i, 32'(cnt_nov), e.cn);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
